// File: rtl/demux1t2_64_stream.sv
// ----------------------------------------------------------------------------
// demux1t2_64_stream
//
// Registered 1-to-2 demultiplexer for a valid/ready stream. Each input beat is
// steered to port 0 or port 1 by in_sel and lands in that port's one-entry
// output register. The two ports are independent: a stalled consumer only
// back-pressures beats addressed to its own port.
//
// Optional feature (macro DEMUX1T2_64_STREAM_COUNT_EN):
//   defined   - o0_count / o1_count count output transfers per port and
//               saturate at 2^CNT_W-1.
//   undefined - no counter registers; o0_count / o1_count are tied to zero.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  input beat present
//   in_data   input payload (WIDTH bits)
//   in_sel    destination of the current beat (0 -> port 0, 1 -> port 1)
//   in_ready  input beat accepted when high together with in_valid
//   o0_valid  port 0 holds a beat      o1_valid  port 1 holds a beat
//   o0_data   port 0 payload           o1_data   port 1 payload
//   o0_ready  port 0 consumer accepts  o1_ready  port 1 consumer accepts
//   o0_count  beats delivered on port 0 (optional feature)
//   o1_count  beats delivered on port 1 (optional feature)
// ----------------------------------------------------------------------------
module demux1t2_64_stream #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             o0_valid,
    output logic [WIDTH-1:0] o0_data,
    input  logic             o0_ready,
    output logic             o1_valid,
    output logic [WIDTH-1:0] o1_data,
    input  logic             o1_ready,
    output logic [CNT_W-1:0] o0_count,
    output logic [CNT_W-1:0] o1_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_r [2];
    logic [WIDTH-1:0] data_r  [2];

    logic [1:0] full_s;
    logic [1:0] out_ready_s;
    logic [1:0] take_s;
    logic [1:0] drain_s;
    logic       in_take_s;

    // Handshake decode: in_ready looks only at the addressed port, so a stall
    // on the other port never blocks this beat. in_valid is deliberately not
    // an input to in_ready.
    always_comb begin
        full_s[0]      = (state_r[0] == ST_FULL);
        full_s[1]      = (state_r[1] == ST_FULL);
        out_ready_s[0] = o0_ready;
        out_ready_s[1] = o1_ready;
        if (in_sel) begin
            in_ready = ~full_s[1] | o1_ready;
        end else begin
            in_ready = ~full_s[0] | o0_ready;
        end
        in_take_s = in_valid & in_ready;
        take_s[0] = in_take_s & ~in_sel;
        take_s[1] = in_take_s & in_sel;
        drain_s   = full_s & out_ready_s;
    end

    // Per-port one-entry register FSM; a FULL port that drains and refills in
    // the same cycle stays FULL so back-to-back beats flow without a bubble.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                state_r[p] <= ST_EMPTY;
                data_r[p]  <= {WIDTH{1'b0}};
            end else begin
                case (state_r[p])
                    ST_EMPTY: begin
                        if (take_s[p]) begin
                            state_r[p] <= ST_FULL;
                            data_r[p]  <= in_data;
                        end else begin
                            state_r[p] <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (take_s[p]) begin
                            state_r[p] <= ST_FULL;
                            data_r[p]  <= in_data;
                        end else if (drain_s[p]) begin
                            state_r[p] <= ST_EMPTY;
                        end else begin
                            state_r[p] <= ST_FULL;
                        end
                    end
                    default: begin
                        state_r[p] <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o0_valid = full_s[0];
    assign o1_valid = full_s[1];
    assign o0_data  = data_r[0];
    assign o1_data  = data_r[1];

`ifdef DEMUX1T2_64_STREAM_COUNT_EN
    logic [CNT_W-1:0] cnt_r [2];

    // Delivered-beat counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                cnt_r[p] <= {CNT_W{1'b0}};
            end else if (drain_s[p] && !(&cnt_r[p])) begin
                cnt_r[p] <= cnt_r[p] + CNT_W'(1);
            end else begin
                cnt_r[p] <= cnt_r[p];
            end
        end
    end

    assign o0_count = cnt_r[0];
    assign o1_count = cnt_r[1];
`else
    assign o0_count = {CNT_W{1'b0}};
    assign o1_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/demux1t2_64_stream.md
Name: demux1t2_64_stream

Overview:
- Registered 1-to-2 demultiplexer for 64-bit data; the inverse of the 2:1 64-bit mux element.
- A single valid/ready input stream is steered to output port 0 or port 1 by a per-beat select bit.
- Each output port has a one-entry output register, so a stall on one port does not block traffic routed to the other.
- Sits between a single producer and two independent consumers in the element library.

Parameters:
- WIDTH, 64, data width of input and both output ports.
- CNT_W, 16, width of the per-port beat counters (used only when the optional feature is enabled).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_data  input  WIDTH  input payload.
- in_sel  input  1  destination of the current beat: 0 → port 0, 1 → port 1.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- o0_valid  output  1  port 0 holds a beat.
- o0_data  output  WIDTH  port 0 payload.
- o0_ready  input  1  port 0 consumer accepts.
- o1_valid  output  1  port 1 holds a beat.
- o1_data  output  WIDTH  port 1 payload.
- o1_ready  input  1  port 1 consumer accepts.
- o0_count  output  CNT_W  beats delivered on port 0 (optional feature only).
- o1_count  output  CNT_W  beats delivered on port 1 (optional feature only).

Behaviour:
- Per-port state machine with two states:
  - EMPTY: ox_valid=0.
  - FULL: ox_valid=1, ox_data stable.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer on port x: ox_valid & ox_ready.
- in_ready is combinational: in_sel ? (~o1_valid | o1_ready) : (~o0_valid | o0_ready). It may depend on in_sel and ox_ready. It must not depend on in_valid.
- Port x transitions:
  - EMPTY → FULL on an input transfer with in_sel==x; ox_data <= in_data.
  - FULL → EMPTY on an output transfer with no input transfer to x.
  - FULL → FULL on an output transfer and an input transfer to x in the same cycle; ox_data <= in_data. This is a pass-through at full rate with no bubble.
  - FULL with ox_ready=0 holds ox_data and ox_valid unchanged. in_ready=0 when in_sel selects that port.
- Latency: a beat accepted in cycle N appears on ox_valid/ox_data in cycle N+1.
- Throughput: one beat per cycle per port when the consumer keeps ox_ready high.
- Independence:
  - A FULL, stalled port 0 does not affect acceptance of in_sel=1 beats, and vice versa.
  - Both ports may drain in the same cycle.
- No reordering within a port; beats reach each port in input order.
- Data on a non-targeted port never changes.
- Reset (synchronous, rst high at a rising edge):
  - o0_valid=0, o1_valid=0, o0_data=0, o1_data=0, counters=0.
  - Buffered beats are discarded, including a reset asserted mid-stall.
  - in_ready follows its combinational rule during reset. Input transfers in a reset cycle are ignored.
- in_sel is sampled only on an input transfer; X on in_sel while in_valid=0 has no effect.

Optional Feature:
- Macro: DEMUX1T2_64_STREAM_COUNT_EN.
- Defined:
  - o0_count/o1_count increment by 1 on each output transfer of their port.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - Reset to 0.
- Undefined:
  - Counter registers are not built.
  - o0_count and o1_count are tied to 0. Port list is unchanged.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → o0_valid=o1_valid=0, o0_data=o1_data=0; with o0_ready=0 and in_sel=0, in_ready=1.
- Alternate routing, both ready=1:
  - Stimulus: in_data 64'h5555555555555555 with in_sel=0, then 64'hAAAAAAAAAAAAAAAA with in_sel=1, on consecutive cycles.
  - Response: o0_data=5555… one cycle after the first beat; o1_data=AAAA… one cycle after the second; in_ready held 1.
- Stall isolation:
  - Stimulus: o0_ready=0; send 64'h1 to port 0, then 64'h2 with in_sel=0, then 64'h3 with in_sel=1.
  - Response: port 0 holds 1; in_ready=0 for the 64'h2 beat; 64'h3 accepted and o1_data=3 next cycle; raising o0_ready drains 1, then 64'h2 is accepted.
- Back-to-back pass-through: 8 beats 0..7 to port 1 with o1_ready=1 → o1_valid high for 8 consecutive cycles, data 0..7 in order, no bubble.
- Reset mid-operation: port 0 FULL with 64'hDEAD, o0_ready=0, assert rst → next cycle o0_valid=0, o0_data=0; beat is not delivered after reset release.
- With DEMUX1T2_64_STREAM_COUNT_EN and CNT_W=2: deliver 5 beats on port 1 → o1_count reads 1,2,3,3,3 and o0_count=0. Without the macro → both counts read 0 throughout.
